instr_stream_encoder: RTL and testbench

- Writer side of the instruction path: encodes abstract instruction requests (operation select plus register and immediate fields) into 32-bit MIPS words.
- Buffers encoded words in a small FIFO and streams them into instruction memory at consecutive byte addresses.
- The opcode/funct fields it produces are exactly those the main decoder and the ALU decoder consume: R-type ADD/SUB/AND/OR/SLT, LW, SW, BEQ.
- Used by the bench and boot path to load programs.

---
 rtl/instr_stream_encoder.sv | 184 ++++++++++++++++++
 tb/tb_instr_stream_encoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_encoder.sv
// rtl/instr_stream_encoder.sv - encodes instruction requests into MIPS words and streams them to instruction memory
// Optional $zero-destination rejection is enabled by defining ENC_ZERO_DEST_CHECK_EN.
module instr_stream_encoder #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_busy,
  output logic              done,
  output logic [15:0]       words_written,
  output logic              err_zero
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [31:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_addr;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_done;
  logic [15:0]       r_words;
  logic              r_err_zero;

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_zero_dest;
  logic        w_push;
  logic        w_pop;
  logic        w_wr_done;
  logic        w_is_rtype;
  logic [5:0]  w_funct;
  logic [31:0] w_enc;

  assign w_full     = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign req_ready  = (r_state == S_LOAD) && !w_full;
  assign w_accept   = req_valid && req_ready;
  assign w_is_rtype = (req_op <= 3'd4);

`ifdef ENC_ZERO_DEST_CHECK_EN
  assign w_zero_dest = (w_is_rtype && (req_rd == 5'd0)) || ((req_op == 3'd5) && (req_rt == 5'd0));
`else
  assign w_zero_dest = 1'b0;
`endif

  assign w_push    = w_accept && !w_zero_dest;
  assign w_wr_done = r_imem_we && !imem_busy;
  // The output register is reusable on the same edge its current word completes.
  assign w_pop     = !w_empty && (!r_imem_we || !imem_busy);

  always_comb begin
    w_funct = 6'b100000;
    w_enc   = 32'd0;
    case (req_op)
      3'd0: w_funct = 6'b100000;
      3'd1: w_funct = 6'b100010;
      3'd2: w_funct = 6'b100100;
      3'd3: w_funct = 6'b100101;
      3'd4: w_funct = 6'b101010;
      default: w_funct = 6'b100000;
    endcase
    case (req_op)
      3'd5:    w_enc = {6'b100011, req_rs, req_rt, req_imm};
      3'd6:    w_enc = {6'b101011, req_rs, req_rt, req_imm};
      3'd7:    w_enc = {6'b000100, req_rs, req_rt, req_imm};
      default: w_enc = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, w_funct};
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_enc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_addr       <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 32'd0;
      r_done       <= 1'b0;
      r_words      <= 16'd0;
      r_err_zero   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err_zero <= w_accept && w_zero_dest;

      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_imem_we    <= 1'b1;
        r_imem_addr  <= r_addr;
        r_imem_wdata <= r_fifo[r_rptr];
      end else if (w_wr_done) begin
        r_imem_we <= 1'b0;
      end

      if (w_wr_done && (r_words != 16'hFFFF)) begin
        r_words <= r_words + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_addr  <= base_addr;
            r_words <= 16'd0;
          end
        end
        S_LOAD: begin
          if (w_pop) begin
            r_addr <= r_addr + ADDR_W'(4);
          end
          if (w_accept && req_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop) begin
            r_addr <= r_addr + ADDR_W'(4);
          end
          if (w_empty && !r_imem_we) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_we       = r_imem_we;
  assign imem_addr     = r_imem_addr;
  assign imem_wdata    = r_imem_wdata;
  assign done          = r_done;
  assign words_written = r_words;
  assign err_zero      = r_err_zero;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb/tb_instr_stream_encoder.sv - randomized self-checking bench for instr_stream_encoder
module tb_instr_stream_encoder;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_op = '0;
  logic [4:0]        req_rs = '0;
  logic [4:0]        req_rt = '0;
  logic [4:0]        req_rd = '0;
  logic [15:0]       req_imm = '0;
  logic              req_last = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_busy = 1'b0;
  logic              done;
  logic [15:0]       words_written;
  logic              err_zero;

  instr_stream_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_busy(imem_busy), .done(done),
    .words_written(words_written), .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          wr_cycles[$];
  int          cyc = 0;
  int          err_seen = 0;
  int          m_addr = 0;
  int          m_words = 0;
  int          m_err = 0;
  int          busy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (busy_mode)
      0:       imem_busy = 1'b0;
      1:       imem_busy = 1'b1;
      default: imem_busy = ($urandom_range(0, 2) == 0);
    endcase
  end

  // Scoreboard: every completed write must match the next expected word; stalled outputs must hold.
  logic        p_we = 1'b0, p_busy = 1'b0, p_done = 1'b0;
  logic [31:0] p_addr = '0, p_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      p_we   = 1'b0;
      p_done = 1'b0;
    end else begin
      if (p_we && p_busy) begin
        check("hold_we", 32'(imem_we), 32'd1);
        check("hold_addr", 32'(imem_addr), p_addr);
        check("hold_data", imem_wdata, p_data);
      end
      if (imem_we && !imem_busy) begin
        check("write_expected", 32'(exp_data_q.size() > 0), 32'd1);
        if (exp_data_q.size() > 0) begin
          check("wr_addr", 32'(imem_addr), exp_addr_q.pop_front());
          check("wr_data", imem_wdata, exp_data_q.pop_front());
        end
        wr_cycles.push_back(cyc);
      end
      if (err_zero) err_seen++;
      if (done) check("done_one_cycle", 32'(p_done), 32'd0);
      p_we   = imem_we;
      p_busy = imem_busy;
      p_addr = 32'(imem_addr);
      p_data = imem_wdata;
      p_done = done;
    end
  end

  function automatic logic [31:0] model_enc(input int op, input int rs, input int rt, input int rd, input int imm);
    logic [31:0] funct_tab [5];
    logic [31:0] fields;
    funct_tab[0] = 32'd32; funct_tab[1] = 32'd34; funct_tab[2] = 32'd36;
    funct_tab[3] = 32'd37; funct_tab[4] = 32'd42;
    fields = (32'(rs) << 21) + (32'(rt) << 16);
    case (op)
      5:       return (32'd35 << 26) + fields + 32'(imm);
      6:       return (32'd43 << 26) + fields + 32'(imm);
      7:       return (32'd4 << 26) + fields + 32'(imm);
      default: return fields + (32'(rd) << 11) + funct_tab[op];
    endcase
  endfunction

  function automatic bit model_reject(input int op, input int rt, input int rd);
`ifdef ENC_ZERO_DEST_CHECK_EN
    return ((op <= 4) && (rd == 0)) || ((op == 5) && (rt == 0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_start(input int base);
    base_addr = base[ADDR_W-1:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_addr = base;
    m_words = 0;
    m_err = 0;
    err_seen = 0;
  endtask

  task automatic send_req(input int op, input int rs, input int rt, input int rd, input int imm,
                          input bit last, input bit use_lit, input logic [31:0] lit, input int gap);
    bit acc;
    repeat (gap) begin
      req_valid = 1'b0;
      @(posedge clk); #1;
    end
    req_op = op[2:0]; req_rs = rs[4:0]; req_rt = rt[4:0]; req_rd = rd[4:0];
    req_imm = imm[15:0]; req_last = last; req_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    check("req_accepted", 32'(acc), 32'd1);
    if (acc) begin
      if (model_reject(op, rt, rd)) begin
        m_err++;
      end else begin
        exp_addr_q.push_back(32'(m_addr & ((1 << ADDR_W) - 1)));
        exp_data_q.push_back(use_lit ? lit : model_enc(op, rs, rt, rd, imm));
        m_addr += 4;
        m_words++;
      end
    end
    if (last) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("words_written", 32'(words_written), 32'(m_words));
      check("queue_drained", 32'(exp_data_q.size()), 32'd0);
      check("err_pulses", 32'(err_seen), 32'(m_err));
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_req(input bit last, input int gap);
    int op, rs, rt, rd, imm;
    op = $urandom_range(0, 7); rs = $urandom_range(0, 31); rt = $urandom_range(0, 31);
    rd = $urandom_range(0, 31); imm = $urandom_range(0, 65535);
    send_req(op, rs, rt, rd, imm, last, 1'b0, 32'd0, gap);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_data", imem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_err", 32'(err_zero), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single ADD: latency and first-session behaviour.
    do_start(32'h100);
    send_req(0, 1, 2, 3, 0, 1'b1, 1'b1, 32'h00221820, 0);
    @(negedge clk);
    check("lat_edge_k", 32'(imem_we), 32'd0);
    @(negedge clk);
    check("lat_edge_k1_we", 32'(imem_we), 32'd1);
    check("lat_edge_k1_addr", 32'(imem_addr), 32'h100);
    wait_done();

    // Back-to-back burst with fixed encodings; one write per cycle.
    wr_cycles.delete();
    do_start(32'h200);
    send_req(1, 4, 5, 6, 0, 1'b0, 1'b1, 32'h00853022, 0);
    send_req(5, 0, 8, 0, 4, 1'b0, 1'b1, 32'h8C080004, 0);
    send_req(6, 29, 31, 0, 16'hFFFC, 1'b0, 1'b1, 32'hAFBFFFFC, 0);
    send_req(7, 1, 2, 0, 16'hFFFF, 1'b1, 1'b1, 32'h1022FFFF, 0);
    wait_done();
    check("burst_writes", 32'(wr_cycles.size()), 32'd4);
    for (int i = 1; i < wr_cycles.size(); i++)
      check("burst_spacing", 32'(wr_cycles[i] - wr_cycles[i-1]), 32'd1);

    // Stalled memory: FIFO fills, ready drops, nothing lost.
    busy_mode = 1;
    @(posedge clk); #1;
    do_start(32'h040);
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_req(i % 5, i + 1, i + 2, i + 3, 0, (i == 5), 1'b0, 32'd0, 0);
      end
      begin
        repeat (7) @(posedge clk);
        #2;
        check("ready_low_full", 32'(req_ready), 32'd0);
        busy_mode = 0;
      end
    join
    wait_done();

    // Address wrap at the top of the space.
    do_start(32'h3FC);
    send_req(3, 7, 8, 9, 0, 1'b0, 1'b0, 32'd0, 0);
    send_req(6, 10, 11, 0, 16'h0010, 1'b1, 1'b0, 32'd0, 0);
    wait_done();

    // Asynchronous reset with queued words; no writes afterwards.
    busy_mode = 1;
    @(posedge clk); #1;
    do_start(32'h080);
    send_req(0, 1, 1, 1, 0, 1'b0, 1'b0, 32'd0, 0);
    send_req(1, 2, 2, 2, 0, 1'b0, 1'b0, 32'd0, 0);
    send_req(2, 3, 3, 3, 0, 1'b0, 1'b0, 32'd0, 0);
    #3;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check("arst_we", 32'(imem_we), 32'd0);
    check("arst_addr", 32'(imem_addr), 32'd0);
    check("arst_data", imem_wdata, 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    busy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wr_cycles.delete();
    repeat (10) @(posedge clk);
    #1;
    check("no_write_after_rst", 32'(wr_cycles.size()), 32'd0);
    check("idle_after_rst", 32'(req_ready), 32'd0);
    do_start(32'h000);
    for (int i = 0; i < 3; i++) rand_req(i == 2, 0);
    wait_done();

    // $zero destinations: rejected when the check is built in, encoded otherwise.
    do_start(32'h120);
    send_req(0, 1, 2, 0, 0, 1'b0, 1'b0, 32'd0, 0);
    send_req(5, 3, 0, 0, 8, 1'b0, 1'b0, 32'd0, 0);
    send_req(3, 1, 2, 3, 0, 1'b1, 1'b1, 32'h00221825, 0);
    wait_done();

    // Random sessions with random stalls and valid gaps; one has a stray start mid-load.
    busy_mode = 2;
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 8);
      do_start(int'($urandom_range(0, 255)) * 4);
      for (int i = 0; i < n; i++) begin
        rand_req(i == n - 1, $urandom_range(0, 2));
        if (s == 2 && i == 0 && n > 1) begin
          req_valid = 1'b0;
          base_addr = ADDR_W'($urandom_range(0, 1023));
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      wait_done();
    end
    busy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
